alu32_rr_sched: RTL and testbench

//  Shares one alu32 instance between NUM_REQ independent requesters.

---
 rtl/alu32_pkg.sv | 24 ++
 rtl/alu32_rr_sched_pkg.sv | 19 +
 rtl/alu32_rr_sched_if.sv | 32 +++
 rtl/alu32.sv | 35 +++
 rtl/alu32_rr_sched_rr_arbiter.sv | 26 ++
 rtl/alu32_rr_sched.sv | 92 +++++++++
 tb/tb_alu32_rr_sched.sv | 246 ++++++++++++++++++++++++
 7 files changed

// File: rtl/alu32_pkg.sv
// Opcode encodings and legality check shared by the ALU and its schedulers.
// Pure definitions: no latency, no backpressure.
// Used by every block that drives or decodes an ALU opcode.
package alu32_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] OP_ADD = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] OP_SUB = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] OP_AND = 4'b0011;
  localparam logic [ALU_SEL_W-1:0] OP_OR  = 4'b0100;
  localparam logic [ALU_SEL_W-1:0] OP_XOR = 4'b0101;
  localparam logic [ALU_SEL_W-1:0] OP_SLT = 4'b0111;
  localparam logic [ALU_SEL_W-1:0] OP_SLL = 4'b1000;
  localparam logic [ALU_SEL_W-1:0] OP_SRL = 4'b1001;

  function automatic logic is_legal_op(input logic [ALU_SEL_W-1:0] sel);
    case (sel)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL: is_legal_op = 1'b1;
      default:                                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu32_rr_sched_pkg.sv
// Scheduler-local types: FSM state encoding and the latched operand bundle.
// Pure definitions: no latency, no backpressure.
// Shared by the scheduler top and anything that inspects its state.
package alu32_rr_sched_pkg;
  import alu32_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [ALU_SEL_W-1:0] sel;
  } op_t;

endpackage

// File: rtl/alu32_rr_sched_if.sv
// Request/response bundle between issuing clients (master) and the scheduler (slave).
// Wires only: no latency; Req_Ready and Rsp_Ready carry the backpressure.
// Per-requester fields are packed with requester i at the i-th slice.
interface alu32_rr_sched_if
  import alu32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]           Req_Valid;
  logic [NUM_REQ-1:0]           Req_Ready;
  logic [32*NUM_REQ-1:0]        Req_A;
  logic [32*NUM_REQ-1:0]        Req_B;
  logic [ALU_SEL_W*NUM_REQ-1:0] Req_Sel;
  logic                         Rsp_Valid;
  logic                         Rsp_Ready;
  logic [ID_W-1:0]              Rsp_Id;
  logic [31:0]                  Rsp_Out;
  logic                         Rsp_Carry;
  logic                         Rsp_Err;
  logic                         Busy;

  modport master (
    output Req_Valid, Req_A, Req_B, Req_Sel, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Out, Rsp_Carry, Rsp_Err, Busy
  );

  modport slave (
    input  Req_Valid, Req_A, Req_B, Req_Sel, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Id, Rsp_Out, Rsp_Carry, Rsp_Err, Busy
  );
endinterface

// File: rtl/alu32.sv
// Combinational 32-bit ALU; CarryOut is meaningful for ADD/SUB only.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers inputs/outputs as needed.
module alu32
  import alu32_pkg::*;
(
  input  logic [31:0]          A,
  input  logic [31:0]          B,
  input  logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic [31:0]          ALU_Out,
  output logic                 CarryOut
);
  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  // SUB carry is the no-borrow flag of A + ~B + 1, i.e. set when A >= B unsigned.
  assign diff = {1'b0, A} + {1'b0, ~B} + 33'd1;

  always_comb begin
    ALU_Out  = '0;
    CarryOut = 1'b0;
    case (ALU_Sel)
      OP_ADD: {CarryOut, ALU_Out} = sum;
      OP_SUB: {CarryOut, ALU_Out} = diff;
      OP_AND: ALU_Out = A & B;
      OP_OR:  ALU_Out = A | B;
      OP_XOR: ALU_Out = A ^ B;
      OP_SLT: ALU_Out = {31'd0, $signed(A) < $signed(B)};
      OP_SLL: ALU_Out = A << B[4:0];
      OP_SRL: ALU_Out = A >> B[4:0];
      default: ;
    endcase
  end
endmodule

// File: rtl/alu32_rr_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
// Latency: 0 cycles (combinational); the caller owns and advances the pointer.
// Backpressure: grant is only a proposal; the caller decides whether it is taken.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                        = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx                        = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/alu32_rr_sched.sv
// Shares one alu32 between NUM_REQ requesters via round-robin grant, returns tagged results.
// Latency: accept in cycle T, Rsp_Valid from T+2; one op in flight, 1 op per 3 cycles max.
// Backpressure: Rsp_Ready low holds RESP with Rsp_* stable; Req_Ready stays 0 until IDLE.
module alu32_rr_sched
  import alu32_pkg::*;
  import alu32_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu32_rr_sched_if.slave  bus
);
  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  win_gnt;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;
  op_t                 op_q;
  logic [ID_W-1:0]     id_q;
  logic [31:0]         alu_out;
  logic                alu_carry;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req   (bus.Req_Valid),
    .ptr   (rr_ptr),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  alu32 u_alu (
    .A        (op_q.a),
    .B        (op_q.b),
    .ALU_Sel  (op_q.sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  // Grant is offered only in IDLE and out of reset, so a proposal is always taken.
  assign bus.Req_Ready = (rst_n && state == ST_IDLE) ? win_gnt : '0;
  assign bus.Busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      op_q          <= '0;
      id_q          <= '0;
      bus.Rsp_Valid <= 1'b0;
      bus.Rsp_Id    <= '0;
      bus.Rsp_Out   <= '0;
      bus.Rsp_Carry <= 1'b0;
      bus.Rsp_Err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            op_q.a   <= bus.Req_A[32*int'(win_idx) +: 32];
            op_q.b   <= bus.Req_B[32*int'(win_idx) +: 32];
            op_q.sel <= bus.Req_Sel[ALU_SEL_W*int'(win_idx) +: ALU_SEL_W];
            id_q     <= win_idx;
            rr_ptr   <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.Rsp_Id    <= id_q;
          bus.Rsp_Valid <= 1'b1;
          if (is_legal_op(op_q.sel)) begin
            bus.Rsp_Out   <= alu_out;
            bus.Rsp_Carry <= alu_carry;
            bus.Rsp_Err   <= 1'b0;
          end else begin
            bus.Rsp_Out   <= '0;
            bus.Rsp_Carry <= 1'b0;
            bus.Rsp_Err   <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.Rsp_Ready) begin
            bus.Rsp_Valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu32_rr_sched.sv
// Directed bench for alu32_rr_sched: per-cycle reference model plus response scoreboard.
module tb_alu32_rr_sched;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu32_rr_sched_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
  alu32_rr_sched #(.NUM_REQ(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  id;
    logic [31:0] out;
    logic        carry;
    logic        err;
  } rsp_t;
  typedef enum int {M_IDLE, M_EXEC, M_RESP} mst_t;

  logic [N-1:0] valid, keep;
  logic [31:0]  ta [N];
  logic [31:0]  tbv[N];
  logic [3:0]   ts [N];
  logic         rsp_ready;

  rsp_t sb[$];
  mst_t m_state  = M_IDLE;
  int   m_ptr    = 0;
  int   last_gnt = -1;
  int   n_rsp    = 0;
  int   tests    = 0;
  int   fails    = 0;

  always_comb begin
    bus.Req_Valid = valid;
    bus.Rsp_Ready = rsp_ready;
    bus.Req_A     = '0;
    bus.Req_B     = '0;
    bus.Req_Sel   = '0;
    for (int i = 0; i < N; i++) begin
      bus.Req_A[32*i +: 32] = ta[i];
      bus.Req_B[32*i +: 32] = tbv[i];
      bus.Req_Sel[4*i +: 4] = ts[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    logic [32:0] t;
    rsp_t r;
    r.id = '0; r.out = '0; r.carry = 1'b0; r.err = 1'b0;
    case (s)
      4'h0: begin t = {1'b0, a} + {1'b0, b}; r.out = t[31:0]; r.carry = t[32]; end
      4'h2: begin r.out = a - b; r.carry = (a >= b); end
      4'h3: r.out = a & b;
      4'h4: r.out = a | b;
      4'h5: r.out = a ^ b;
      4'h7: r.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r.out = a << b[4:0];
      4'h9: r.out = a >> b[4:0];
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    logic found = 1'b0;
    rr_pick = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && v[(p + k) % N]) begin
        found = 1'b1;
        rr_pick[(p + k) % N] = 1'b1;
      end
    end
  endfunction

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    logic [N-1:0] g;
    rsp_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("req_ready_in_reset", bus.Req_Ready, '0);
      m_state = M_IDLE; m_ptr = 0; sb.delete(); last_gnt = -1;
    end else begin
      chk("busy", bus.Busy, m_state != M_IDLE);
      chk("rsp_valid", bus.Rsp_Valid, m_state == M_RESP);
      chk("req_ready_onehot0", $onehot0(bus.Req_Ready), 1);
      g = (m_state == M_IDLE) ? rr_pick(valid, m_ptr) : '0;
      chk("req_ready", bus.Req_Ready, g);
      case (m_state)
        M_IDLE: if (g != '0) begin
          for (int i = 0; i < N; i++) if (g[i]) last_gnt = i;
          e = ref_alu(ta[last_gnt], tbv[last_gnt], ts[last_gnt]);
          e.id = 2'(last_gnt);
          sb.push_back(e);
          m_ptr = (last_gnt + 1) % N;
          m_state = M_EXEC;
        end
        M_EXEC: m_state = M_RESP;
        default: begin
          if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            e = sb[0];
            chk("rsp_id", bus.Rsp_Id, e.id);
            chk("rsp_out", bus.Rsp_Out, e.out);
            chk("rsp_carry", bus.Rsp_Carry, e.carry);
            chk("rsp_err", bus.Rsp_Err, e.err);
            if (rsp_ready) begin
              void'(sb.pop_front());
              n_rsp++;
              m_state = M_IDLE;
            end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (last_gnt >= 0 && !keep[last_gnt]) valid[last_gnt] = 1'b0;
    last_gnt = -1;
  endtask

  task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    ta[r] = a; tbv[r] = b; ts[r] = s; valid[r] = 1'b1;
  endtask

  task automatic run_ops(input string tag, input int n);
    int target = n_rsp + n;
    for (int k = 0; k < 200 && n_rsp < target; k++) step();
    chk(tag, n_rsp, target);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, bus.Req_Ready, '0);
    chk({tag, "_rsp_valid"}, bus.Rsp_Valid, 0);
    chk({tag, "_rsp_id"},    bus.Rsp_Id, 0);
    chk({tag, "_rsp_out"},   bus.Rsp_Out, 0);
    chk({tag, "_rsp_carry"}, bus.Rsp_Carry, 0);
    chk({tag, "_rsp_err"},   bus.Rsp_Err, 0);
    chk({tag, "_busy"},      bus.Busy, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero(tag);
  endtask

  initial begin
    valid = '0; keep = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin ta[i] = '0; tbv[i] = '0; ts[i] = '0; end
    step();
    do_reset("por");

    // Single ADD from requester 0
    drive(0, 32'd10, 32'd5, 4'b0000);
    run_ops("t1_done", 1);
    chk("t1_out", bus.Rsp_Out, 32'd15);
    chk("t1_id", bus.Rsp_Id, 0);
    chk("t1_err", bus.Rsp_Err, 0);

    // Carry out of ADD, then SUB
    drive(1, 32'hFFFF_FFFF, 32'd1, 4'b0000);
    run_ops("t2_done", 1);
    chk("t2_out", bus.Rsp_Out, 32'd0);
    chk("t2_carry", bus.Rsp_Carry, 1);
    chk("t2_id", bus.Rsp_Id, 1);
    drive(1, 32'd10, 32'd5, 4'b0010);
    run_ops("t2_sub_done", 1);
    chk("t2_sub_out", bus.Rsp_Out, 32'd5);

    // Round-robin with all requesters continuously valid
    do_reset("rst_pre_rr");
    keep = '1;
    drive(0, 32'd10, 32'd5, 4'b0011);
    drive(1, 32'd10, 32'd5, 4'b0100);
    drive(2, 32'd10, 32'd5, 4'b0101);
    drive(3, 32'd10, 32'd5, 4'b0111);
    run_ops("t3_done", 5);
    valid = '0; keep = '0;
    chk("t3_last_id", bus.Rsp_Id, 0);
    chk("t3_last_out", bus.Rsp_Out, 32'd0);

    // Backpressure: response held, waiting requester not granted
    rsp_ready = 1'b0;
    drive(3, 32'd1, 32'd2, 4'b0000);
    drive(0, 32'd7, 32'd8, 4'b0000);
    for (int k = 0; k < 20 && !bus.Rsp_Valid; k++) step();
    chk("t4_rsp_valid_seen", bus.Rsp_Valid, 1);
    repeat (5) step();
    chk("t4_hold_out", bus.Rsp_Out, 32'd3);
    chk("t4_hold_id", bus.Rsp_Id, 3);
    chk("t4_no_grant", bus.Req_Ready, '0);
    rsp_ready = 1'b1;
    step();
    chk("t4_regrant", bus.Req_Ready, 4'b0001);
    run_ops("t4_done", 1);
    chk("t4_next_out", bus.Rsp_Out, 32'd15);

    // Illegal opcode
    drive(2, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0001);
    run_ops("t5_done", 1);
    chk("t5_err", bus.Rsp_Err, 1);
    chk("t5_out", bus.Rsp_Out, 32'd0);
    chk("t5_carry", bus.Rsp_Carry, 0);
    chk("t5_id", bus.Rsp_Id, 2);

    // Reset while in EXEC: op is dropped and pointer returns to 0
    drive(2, 32'd3, 32'd4, 4'b0000);
    for (int k = 0; k < 20 && !bus.Busy; k++) step();
    chk("t6_exec_busy", bus.Busy, 1);
    do_reset("rst_exec");
    repeat (4) step();
    drive(3, 32'd9, 32'd9, 4'b0011);
    drive(0, 32'd6, 32'd3, 4'b0010);
    #1;
    chk("t6_ptr0", bus.Req_Ready, 4'b0001);
    run_ops("t6_done", 2);

    // Reset while in RESP
    rsp_ready = 1'b0;
    drive(1, 32'd20, 32'd2, 4'b1000);
    for (int k = 0; k < 20 && !bus.Rsp_Valid; k++) step();
    chk("t6_resp_valid", bus.Rsp_Valid, 1);
    chk("t6_resp_out", bus.Rsp_Out, 32'd80);
    repeat (2) step();
    do_reset("rst_resp");
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
